// File: rtl/regi.sv
// ---------------------------------------------------------------------------
// regi : clock-enabled, asynchronously reset N-bit data register.
//
// Captures d into q on a rising clk edge while ena is high and holds q while
// ena is low. An asynchronous active-high reset forces q to RST_VAL
// immediately, with no clock edge needed. upd is a registered strobe that is
// high for the cycle following any edge on which a load happened.
//
// Optional feature macro: REGI_PARITY_EN
//   When defined, adds output q_par. q_par is a flop loaded with ^d alongside
//   q, so it always equals ^q without an XOR tree on the output path.
//
// Parameters
//   WIDTH    data width of d/q, 1..64
//   RST_VAL  reset value of q, truncated or zero-extended to WIDTH
//
// Ports
//   clk    in   1      clock, rising edge
//   rst    in   1      asynchronous reset, active high
//   d      in   WIDTH  data to capture
//   ena    in   1      load enable (1 = capture d, 0 = hold)
//   q      out  WIDTH  registered data
//   upd    out  1      1 for the cycle after any load edge
//   q_par  out  1      even parity of q (REGI_PARITY_EN only)
// ---------------------------------------------------------------------------
module regi #(
    parameter int          WIDTH   = 8,
    parameter logic [63:0] RST_VAL = 64'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             ena,
    output logic [WIDTH-1:0] q,
    output logic             upd
`ifdef REGI_PARITY_EN
    ,
    output logic             q_par
`endif
);

    // Reset value resized to the data width. Slicing a 64-bit parameter
    // truncates wide values; narrow values arrive already zero-extended.
    localparam logic [WIDTH-1:0] RV = RST_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] r_q;
    logic             r_upd;

    // Data register. While ena is low, d is never sampled, so an X on d
    // cannot reach q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RV;
        end else if (ena) begin
            r_q <= d;
        end
    end

    // Load strobe. There is no value compare: reloading the same data still
    // pulses upd, and back-to-back loads keep it high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_upd <= 1'b0;
        end else begin
            r_upd <= ena;
        end
    end

    assign q   = r_q;
    assign upd = r_upd;

`ifdef REGI_PARITY_EN
    localparam logic RV_PAR = ^RV;

    logic r_q_par;

    // Parity is loaded on the same edges as q, so it tracks ^q exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q_par <= RV_PAR;
        end else if (ena) begin
            r_q_par <= ^d;
        end
    end

    assign q_par = r_q_par;
`endif

endmodule

// File: tb/tb_regi.sv
module tb_regi;

  logic       clk;
  logic       rst;
  logic [7:0] d;
  logic       ena;
  logic [7:0] q0, q1;
  logic       upd0, upd1;
`ifdef REGI_PARITY_EN
  logic       par0, par1;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  bit done   = 1'b0;

  regi #(.WIDTH(8), .RST_VAL(64'h00)) dut0 (
    .clk(clk), .rst(rst), .d(d), .ena(ena), .q(q0), .upd(upd0)
`ifdef REGI_PARITY_EN
    , .q_par(par0)
`endif
  );

  regi #(.WIDTH(8), .RST_VAL(64'h5A)) dut1 (
    .clk(clk), .rst(rst), .d(d), .ena(ena), .q(q1), .upd(upd1)
`ifdef REGI_PARITY_EN
    , .q_par(par1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    if (!done) begin
      n_fail++;
      $error("FAIL timeout: test did not finish within the wait limit");
      $finish;
    end
  end

  initial begin
    rst = 1'b1; ena = 1'b0; d = 8'h00;
    #1;
    n_chk++;
    if (q0 !== 8'h00 || upd0 !== 1'b0 || q1 !== 8'h5A || upd1 !== 1'b0) begin
      n_fail++;
      $error("FAIL rst_state: q0=%h upd0=%b q1=%h upd1=%b", q0, upd0, q1, upd1);
    end
    n_chk++; if (q0 !== 8'h00) begin n_fail++; $error("FAIL rst_q0: %h", q0); end
    n_chk++; if (upd0 !== 1'b0) begin n_fail++; $error("FAIL rst_upd0: %b", upd0); end
    n_chk++; if (q1 !== 8'h5A) begin n_fail++; $error("FAIL rst_q1: %h", q1); end
    n_chk++; if (upd1 !== 1'b0) begin n_fail++; $error("FAIL rst_upd1: %b", upd1); end
`ifdef REGI_PARITY_EN
    n_chk++; if (par1 !== 1'b0) begin n_fail++; $error("FAIL rst_par1: %b", par1); end
`endif

    ena = 1'b1; d = 8'hFF;
    step();
    n_chk++; if (q0 !== 8'h00) begin n_fail++; $error("FAIL rvse_q0: %h", q0); end
    n_chk++; if (q1 !== 8'h5A) begin n_fail++; $error("FAIL rvse_q1: %h", q1); end
    n_chk++; if (upd0 !== 1'b0) begin n_fail++; $error("FAIL rvse_upd0: %b", upd0); end

    rst = 1'b0;
    step();
    n_chk++; if (q0 !== 8'hFF) begin n_fail++; $error("FAIL rel_q0: %h", q0); end
    n_chk++; if (q1 !== 8'hFF) begin n_fail++; $error("FAIL rel_q1: %h", q1); end
    n_chk++; if (upd0 !== 1'b1) begin n_fail++; $error("FAIL rel_upd0: %b", upd0); end

    d = 8'h00;
    step();
    n_chk++; if (q0 !== 8'h00) begin n_fail++; $error("FAIL ld00_q: %h", q0); end
    n_chk++; if (upd0 !== 1'b1) begin n_fail++; $error("FAIL ld00_upd: %b", upd0); end
    d = 8'hA5;
    step();
    n_chk++; if (q0 !== 8'hA5) begin n_fail++; $error("FAIL ldA5_q: %h", q0); end
    n_chk++; if (upd0 !== 1'b1) begin n_fail++; $error("FAIL ldA5_upd: %b", upd0); end
`ifdef REGI_PARITY_EN
    n_chk++; if (par0 !== 1'b0) begin n_fail++; $error("FAIL ldA5_par: %b", par0); end
`endif

    ena = 1'b0; d = 8'hF0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++; if (q0 !== 8'hA5) begin n_fail++; $error("FAIL hold_q: %h", q0); end
      n_chk++; if (upd0 !== 1'b0) begin n_fail++; $error("FAIL hold_upd: %b", upd0); end
    end

    d = 8'hxx;
    step();
    n_chk++; if (q0 !== 8'hA5) begin n_fail++; $error("FAIL holdx_q: %h", q0); end
    n_chk++; if (upd0 !== 1'b0) begin n_fail++; $error("FAIL holdx_upd: %b", upd0); end

    #2;
    rst = 1'b1;
    #1;
    n_chk++; if (q0 !== 8'h00) begin n_fail++; $error("FAIL arst_q0: %h", q0); end
    n_chk++; if (q1 !== 8'h5A) begin n_fail++; $error("FAIL arst_q1: %h", q1); end
    n_chk++; if (upd0 !== 1'b0) begin n_fail++; $error("FAIL arst_upd0: %b", upd0); end
    rst = 1'b0; d = 8'hF0;
    step();
    step();
    n_chk++; if (q0 !== 8'h00) begin n_fail++; $error("FAIL arel_q0: %h", q0); end
    n_chk++; if (q1 !== 8'h5A) begin n_fail++; $error("FAIL arel_q1: %h", q1); end
    n_chk++; if (upd0 !== 1'b0) begin n_fail++; $error("FAIL arel_upd0: %b", upd0); end

    ena = 1'b1; d = 8'h33;
    step();
    n_chk++; if (q0 !== 8'h33) begin n_fail++; $error("FAIL same1_q: %h", q0); end
    n_chk++; if (upd0 !== 1'b1) begin n_fail++; $error("FAIL same1_upd: %b", upd0); end
    step();
    n_chk++; if (q0 !== 8'h33) begin n_fail++; $error("FAIL same2_q: %h", q0); end
    n_chk++; if (upd0 !== 1'b1) begin n_fail++; $error("FAIL same2_upd: %b", upd0); end

    d = 8'h07;
    step();
    n_chk++; if (q1 !== 8'h07) begin n_fail++; $error("FAIL ld07_q: %h", q1); end
`ifdef REGI_PARITY_EN
    n_chk++; if (par0 !== 1'b1) begin n_fail++; $error("FAIL ld07_par: %b", par0); end
`endif
    ena = 1'b0; d = 8'h01;
    step();
    n_chk++; if (q0 !== 8'h07) begin n_fail++; $error("FAIL h07_q: %h", q0); end
    n_chk++; if (upd0 !== 1'b0) begin n_fail++; $error("FAIL h07_upd: %b", upd0); end
`ifdef REGI_PARITY_EN
    n_chk++; if (par0 !== 1'b1) begin n_fail++; $error("FAIL h07_par: %b", par0); end
`endif

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
